// File: rtl/pe_pkg.sv
// Shared widths, latency and arithmetic helpers for the signed MAC processing element.
package pe_pkg;
  localparam int DATA_W  = 8;
  localparam int TAPS    = 9;
  localparam int BIAS_W  = 16;
  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 5;
  localparam int PE_LAT  = 4;

  // Round-half-up arithmetic right shift; evaluated in 64 bits so the rounding add never wraps.
  function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v,
                                                   input int unsigned       sh);
    logic signed [63:0] r;
    if (sh == 0) r = v;
    else         r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    return r;
  endfunction

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction
endpackage

// File: rtl/pe_mac_pipe_requant.sv
// Combinational requantiser: rounding shift, optional ReLU, saturation to DATA_W.
module pe_requant
  import pe_pkg::*;
#(
  parameter int DATA_W  = pe_pkg::DATA_W,
  parameter int ACC_W   = pe_pkg::ACC_W,
  parameter int SHIFT_W = pe_pkg::SHIFT_W
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      relu_en_i,
  output logic signed [DATA_W-1:0] data_o
);
  logic signed [63:0] ext;
  logic signed [63:0] rnd;
  logic signed [63:0] clp;
  logic signed [63:0] sat;

  always_comb begin
    ext    = 64'(acc_i);
    rnd    = rnd_shift(ext, 32'(shift_i));
    clp    = (relu_en_i && (rnd < 64'sd0)) ? 64'sd0 : rnd;
    sat    = sat_s(clp, DATA_W);
    data_o = DATA_W'(sat);
  end
endmodule

// File: rtl/pe_mac_pipe.sv
// Pipelined TAPS-wide signed MAC with channel accumulation, bias, requantisation and backpressure.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int DATA_W  = pe_pkg::DATA_W,
  parameter int TAPS    = pe_pkg::TAPS,
  parameter int BIAS_W  = pe_pkg::BIAS_W,
  parameter int ACC_W   = pe_pkg::ACC_W,
  parameter int SHIFT_W = pe_pkg::SHIFT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W*TAPS-1:0]     in_data,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [DATA_W*TAPS-1:0]     weight_data,
  input  logic                       weight_load,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic                       relu_en,
  input  logic                       act_signed,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       seq_err
);
  localparam int PW = 2 * DATA_W + 1;

  // Handshake: a beat moves in on a rising edge with in_valid & in_ready; a result leaves
  // with out_valid & out_ready. A held result (out_valid & ~out_ready) freezes every stage.
  logic stall;
  logic accept;

  logic [DATA_W*TAPS-1:0] weight_q;

  logic signed [ACC_W-1:0] prod_d [TAPS];
  logic signed [ACC_W-1:0] prod_q [TAPS];
  logic                    s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
  logic signed [BIAS_W-1:0] s1_bias_q;
  logic [SHIFT_W-1:0]      s1_shift_q;

  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic                    s2_valid_q, s2_first_q, s2_last_q, s2_relu_q;
  logic signed [BIAS_W-1:0] s2_bias_q;
  logic [SHIFT_W-1:0]      s2_shift_q;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic                    open_q;
  logic                    eff_first;
  logic                    seq_bad;
  logic                    s3_valid_q, s3_last_q, s3_relu_q;
  logic [SHIFT_W-1:0]      s3_shift_q;

  logic signed [DATA_W-1:0] rq_data;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic                     seq_err_q;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign seq_err   = seq_err_q;

  // Activations widen by one bit so unsigned 0xFF and signed -1 both fit one signed multiply.
  always_comb begin
    logic [DATA_W-1:0]        a;
    logic signed [DATA_W:0]   ax;
    logic signed [DATA_W-1:0] w;
    logic signed [PW-1:0]     p;
    a  = '0;
    ax = '0;
    w  = '0;
    p  = '0;
    for (int i = 0; i < TAPS; i++) begin
      a         = in_data[(TAPS-1-i)*DATA_W +: DATA_W];
      ax        = act_signed ? $signed({a[DATA_W-1], a}) : $signed({1'b0, a});
      w         = $signed(weight_q[(TAPS-1-i)*DATA_W +: DATA_W]);
      p         = PW'(ax) * PW'(w);
      prod_d[i] = ACC_W'(p);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) sum_d = sum_d + prod_q[i];
  end

  // A non-first beat with no open pixel is promoted to first; a first beat on an open pixel restarts.
  always_comb begin
    eff_first = s2_first_q | ~open_q;
    seq_bad   = s2_valid_q & (s2_first_q ? open_q : ~open_q);
    acc_d     = eff_first ? (sum_q + ACC_W'(s2_bias_q)) : (acc_q + sum_q);
  end

  pe_requant #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .acc_i     (acc_q),
    .shift_i   (s3_shift_q),
    .relu_en_i (s3_relu_q),
    .data_o    (rq_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      weight_q    <= '0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_bias_q   <= '0;
      s1_shift_q  <= '0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_relu_q   <= 1'b0;
      s2_bias_q   <= '0;
      s2_shift_q  <= '0;
      acc_q       <= '0;
      open_q      <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_relu_q   <= 1'b0;
      s3_shift_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      // Weight capture ignores the stall so the loader never waits on the output writer.
      if (weight_load) weight_q <= weight_data;
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          prod_q     <= prod_d;
          s1_first_q <= in_first;
          s1_last_q  <= in_last;
          s1_relu_q  <= relu_en;
          s1_bias_q  <= bias;
          s1_shift_q <= shift;
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q      <= sum_d;
          s2_first_q <= s1_first_q;
          s2_last_q  <= s1_last_q;
          s2_relu_q  <= s1_relu_q;
          s2_bias_q  <= s1_bias_q;
          s2_shift_q <= s1_shift_q;
        end
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          acc_q      <= acc_d;
          open_q     <= ~s2_last_q;
          s3_last_q  <= s2_last_q;
          s3_relu_q  <= s2_relu_q;
          s3_shift_q <= s2_shift_q;
          if (seq_bad) seq_err_q <= 1'b1;
        end
        out_valid_q <= s3_valid_q & s3_last_q;
        if (s3_valid_q & s3_last_q) out_data_q <= rq_data;
      end
    end
  end
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe: vector table, scoreboard queue and hand-written multi-cycle sequences.
module tb_pe_mac_pipe;
  localparam int DW = 8;
  localparam int T  = 9;
  localparam int VW = DW * T;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [VW-1:0]         in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_first = 1'b0;
  logic                  in_last = 1'b0;
  logic                  in_ready;
  logic [VW-1:0]         weight_data = '0;
  logic                  weight_load = 1'b0;
  logic signed [15:0]    bias = '0;
  logic [4:0]            shift = '0;
  logic                  relu_en = 1'b0;
  logic                  act_signed = 1'b1;
  logic signed [DW-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic                  seq_err;

  pe_mac_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .weight_data (weight_data),
    .weight_load (weight_load),
    .bias        (bias),
    .shift       (shift),
    .relu_en     (relu_en),
    .act_signed  (act_signed),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .seq_err     (seq_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [VW-1:0]      data;
    logic [VW-1:0]      wts;
    logic signed [15:0] b;
    logic [4:0]         sh;
    logic               re;
    logic               as;
    logic [DW-1:0]      exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      logic [DW-1:0] e;
      n_out  = n_out + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_out: got %0d, expected no output (t=%0t)", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors = errors + 1;
          $display("FAIL out_data: got %0d, expected %0d (t=%0t)", out_data, $signed(e), $time);
        end
      end
    end
  end

  // ---------------- helpers / model ----------------
  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] v;
    for (int i = 0; i < T; i++) v[(T-1-i)*DW +: DW] = DW'(i + 1);
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [DW-1:0] x);
    return {T{x}};
  endfunction

  function automatic logic [DW-1:0] model(input logic [VW-1:0] d, input logic [VW-1:0] w,
                                          input logic signed [15:0] b, input logic [4:0] sh,
                                          input logic re, input logic as);
    longint acc;
    longint av;
    longint wv;
    logic [DW-1:0] a;
    acc = longint'(b);
    for (int i = 0; i < T; i++) begin
      a   = d[(T-1-i)*DW +: DW];
      av  = as ? longint'($signed(a)) : longint'(a);
      wv  = longint'($signed(w[(T-1-i)*DW +: DW]));
      acc = acc + av * wv;
    end
    if (sh != 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
    if (re && acc < 0) acc = 0;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return DW'(acc);
  endfunction

  // ---------------- drivers ----------------
  task automatic load_w(input logic [VW-1:0] w);
    weight_data = w;
    weight_load = 1'b1;
    @(posedge clk);
    #1 weight_load = 1'b0;
  endtask

  task automatic send_beat(input logic [VW-1:0] d, input logic f, input logic l,
                           input logic signed [15:0] b, input logic [4:0] sh,
                           input logic re, input logic as);
    int   n;
    logic rdy;
    in_data = d; in_first = f; in_last = l; bias = b; shift = sh; relu_en = re;
    act_signed = as; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    if (!rdy) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int t0;
    int n;
    int base;
    vec_t v;

    vecs[0] = '{ramp(), splat(8'h01), 16'sd0,    5'd0, 1'b0, 1'b1, 8'd45};
    vecs[1] = '{ramp(), splat(8'h01), 16'sd0,    5'd2, 1'b0, 1'b1, 8'd11};
    vecs[2] = '{splat(8'd127), splat(8'd127), 16'sd0, 5'd0, 1'b0, 1'b1, 8'd127};
    vecs[3] = '{ramp(), splat(8'hFF), 16'sd0,    5'd0, 1'b1, 1'b1, 8'd0};
    vecs[4] = '{ramp(), splat(8'hFF), 16'sd0,    5'd0, 1'b0, 1'b1, 8'hD3};
    vecs[5] = '{splat(8'hFF), splat(8'h01), 16'sd0, 5'd4, 1'b0, 1'b0, 8'd127};
    vecs[6] = '{ramp(), splat(8'h01), -16'sd100, 5'd0, 1'b0, 1'b1, 8'hC9};
    vecs[7] = '{ramp(), splat(8'hFF), -16'sd100, 5'd0, 1'b0, 1'b1, 8'h80};

    // reset state
    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_seq_err", seq_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // single pass with latency measurement
    load_w(splat(8'h01));
    exp_q.push_back(8'd45);
    send_beat(ramp(), 1'b1, 1'b1, 16'sd0, 5'd0, 1'b0, 1'b1);
    t0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("latency", cyc - t0, 3);
    wait_drain();

    // vector table
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      load_w(v.wts);
      exp_q.push_back(v.exp);
      send_beat(v.data, 1'b1, 1'b1, v.b, v.sh, v.re, v.as);
    end
    wait_drain();

    // random single passes against the model
    for (int i = 0; i < 8; i++) begin
      logic [VW-1:0]      d;
      logic [VW-1:0]      w;
      logic signed [15:0] b;
      logic [4:0]         sh;
      logic               re;
      logic               as;
      for (int k = 0; k < T; k++) begin
        d[k*DW +: DW] = DW'($urandom_range(0, 255));
        w[k*DW +: DW] = DW'($urandom_range(0, 255));
      end
      b  = 16'($signed($urandom_range(0, 2000)) - 1000);
      sh = 5'($urandom_range(0, 9));
      re = 1'($urandom_range(0, 1));
      as = 1'($urandom_range(0, 1));
      load_w(w);
      exp_q.push_back(model(d, w, b, sh, re, as));
      send_beat(d, 1'b1, 1'b1, b, sh, re, as);
    end
    wait_drain();

    // channel accumulation over three beats
    load_w(splat(8'h01));
    base = n_out;
    exp_q.push_back(8'd73);
    send_beat(ramp(), 1'b1, 1'b0, 16'sd10, 5'd1, 1'b0, 1'b1);
    send_beat(ramp(), 1'b0, 1'b0, 16'sd10, 5'd1, 1'b0, 1'b1);
    send_beat(ramp(), 1'b0, 1'b1, 16'sd10, 5'd1, 1'b0, 1'b1);
    wait_drain();
    chk("accum_out_count", n_out - base, 1);
    chk("accum_seq_err", seq_err, 0);

    // backpressure: six back-to-back results, output held for five cycles
    base = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          exp_q.push_back(DW'(9 * k));
          send_beat(splat(DW'(k)), 1'b1, 1'b1, 16'sd0, 5'd0, 1'b0, 1'b1);
        end
      end
      begin
        logic blocked;
        int   m;
        m = 0;
        blocked = 1'b0;
        do begin
          @(negedge clk);
          m++;
        end while (!out_valid && m < 50);
        chk("bp_first_valid", out_valid, 1);
        repeat (5) begin
          chk("bp_hold_data", out_data, 9);
          chk("bp_hold_valid", out_valid, 1);
          if (!in_ready) blocked = 1'b1;
          @(negedge clk);
        end
        chk("bp_in_ready_dropped", blocked, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_out_count", n_out - base, 6);

    // weight swap in the same cycle as beat A
    load_w(splat(8'h01));
    weight_data = splat(8'h02);
    weight_load = 1'b1;
    exp_q.push_back(8'd45);
    send_beat(ramp(), 1'b1, 1'b1, 16'sd0, 5'd0, 1'b0, 1'b1);
    weight_load = 1'b0;
    exp_q.push_back(8'd90);
    send_beat(ramp(), 1'b1, 1'b1, 16'sd0, 5'd0, 1'b0, 1'b1);
    wait_drain();

    // non-first beat after reset is promoted to a single pass
    do_reset();
    chk("seq_err_cleared", seq_err, 0);
    load_w(splat(8'h01));
    exp_q.push_back(8'd50);
    send_beat(ramp(), 1'b0, 1'b1, 16'sd5, 5'd0, 1'b0, 1'b1);
    wait_drain();
    chk("seq_err_no_first", seq_err, 1);

    // first beat on an open pixel restarts the accumulation
    do_reset();
    load_w(splat(8'h01));
    send_beat(splat(8'd3), 1'b1, 1'b0, 16'sd0, 5'd0, 1'b0, 1'b1);
    exp_q.push_back(8'd45);
    send_beat(ramp(), 1'b1, 1'b1, 16'sd0, 5'd0, 1'b0, 1'b1);
    wait_drain();
    chk("seq_err_restart", seq_err, 1);

    // reset in the middle of an accumulation
    do_reset();
    load_w(splat(8'h01));
    send_beat(ramp(), 1'b1, 1'b0, 16'sd0, 5'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    do_reset();
    load_w(splat(8'h01));
    exp_q.push_back(8'd18);
    send_beat(splat(8'd2), 1'b1, 1'b1, 16'sd0, 5'd0, 1'b0, 1'b1);
    wait_drain();
    chk("seq_err_after_mid_reset", seq_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
